// File: rtl/bp_dram_ui_responder.sv
// Behavioural DRAM app_* responder: burst writes into a word array, burst reads after a fixed
// latency, with a calibration delay after reset and periodic refresh stalls.
module bp_dram_ui_responder #(
  parameter int unsigned ui_addr_width_p    = 28,
  parameter int unsigned ui_data_width_p    = 64,
  parameter int unsigned burst_len_p        = 8,
  parameter int unsigned els_p              = 1024,
  parameter int unsigned addr_shift_p       = 1,
  parameter int unsigned rd_latency_p       = 4,
  parameter int unsigned init_cycles_p      = 16,
  parameter int unsigned refresh_interval_p = 256,
  parameter int unsigned refresh_cycles_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         app_en_i,
  output logic                         app_rdy_o,
  input  logic [2:0]                   app_cmd_i,
  input  logic [ui_addr_width_p-1:0]   app_addr_i,
  input  logic                         app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0]   app_wdf_data_i,
  input  logic [ui_data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                         app_wdf_end_i,
  output logic                         app_wdf_rdy_o,
  output logic                         app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]   app_rd_data_o,
  output logic                         app_rd_data_end_o,
  output logic                         init_calib_complete_o
);

  localparam int unsigned MaskW  = ui_data_width_p / 8;
  localparam int unsigned IdxW   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned BeatW  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int unsigned InitW  = (init_cycles_p > 1) ? $clog2(init_cycles_p) : 1;
  localparam int unsigned LatW   = (rd_latency_p > 1) ? $clog2(rd_latency_p) : 1;
  localparam int unsigned RefW   = (refresh_interval_p > 1) ? $clog2(refresh_interval_p) : 1;
  localparam int unsigned StallW = (refresh_cycles_p > 1) ? $clog2(refresh_cycles_p) : 1;
  localparam bit          RefreshEn = (refresh_interval_p > 0) && (refresh_cycles_p > 0);

  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(burst_len_p - 1);
  localparam logic [InitW-1:0]  InitLast  = InitW'(init_cycles_p - 1);
  localparam logic [LatW-1:0]   LatLast   = LatW'(rd_latency_p - 1);
  localparam logic [RefW-1:0]   RefLast   = RefW'(refresh_interval_p - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(refresh_cycles_p - 1);
  localparam logic [IdxW-1:0]   BeatMask  = IdxW'(burst_len_p - 1);

  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StWrite,
    StRdWait,
    StRdData
  } state_e;

  state_e                     state_q, state_d;
  logic [InitW-1:0]           init_cnt_q, init_cnt_d;
  logic [LatW-1:0]            lat_cnt_q, lat_cnt_d;
  logic [BeatW-1:0]           beat_q, beat_d;
  logic [IdxW-1:0]            base_q, base_d;
  logic                       calib_q, calib_d;
  logic [RefW-1:0]            ref_cnt_q, ref_cnt_d;
  logic                       ref_pend_q, ref_pend_d;
  logic [StallW-1:0]          stall_cnt_q, stall_cnt_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       rd_end_q, rd_end_d;
  logic [ui_data_width_p-1:0] rd_data_q, rd_data_d;

  logic [ui_data_width_p-1:0] mem_q [els_p];

  logic [ui_addr_width_p-1:0] word_addr;
  logic [IdxW-1:0]            cmd_base;
  logic [IdxW-1:0]            wr_idx;
  logic [IdxW-1:0]            rd_idx;
  logic                       wr_en;
  logic                       unused_addr;

  // Upper address bits alias: only the low IdxW bits of the word address select storage.
  assign word_addr   = app_addr_i >> addr_shift_p;
  assign cmd_base    = word_addr[IdxW-1:0] & ~BeatMask;
  assign unused_addr = ^word_addr;

  assign wr_en  = (state_q == StWrite) && app_wdf_wren_i;
  assign wr_idx = base_q + IdxW'(beat_q);
  assign rd_idx = base_q + IdxW'(beat_d);

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    beat_d        = beat_q;
    base_d        = base_q;
    calib_d       = calib_q;
    rd_valid_d    = 1'b0;
    rd_end_d      = 1'b0;
    app_rdy_o     = 1'b0;
    app_wdf_rdy_o = 1'b0;

    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == InitLast) begin
          init_cnt_d = '0;
          calib_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      StIdle: begin
        app_rdy_o = ~ref_pend_q;
        if (app_en_i && !ref_pend_q) begin
          base_d    = cmd_base;
          beat_d    = '0;
          lat_cnt_d = '0;
          if (app_cmd_i == CmdWrite) begin
            state_d = StWrite;
          end else if (app_cmd_i == CmdRead) begin
            state_d = StRdWait;
          end
        end
      end
      StWrite: begin
        app_wdf_rdy_o = 1'b1;
        if (app_wdf_wren_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      StRdWait: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        // The first beat is loaded on the edge that enters StRdData, so it appears
        // rd_latency_p edges after the accepting one.
        if (lat_cnt_q == LatLast) begin
          lat_cnt_d  = '0;
          beat_d     = '0;
          rd_valid_d = 1'b1;
          rd_end_d   = (LastBeat == '0);
          state_d    = StRdData;
        end
      end
      StRdData: begin
        if (beat_q == LastBeat) begin
          state_d = StIdle;
        end else begin
          beat_d     = beat_q + 1'b1;
          rd_valid_d = 1'b1;
          rd_end_d   = (beat_d == LastBeat);
        end
      end
      default: state_d = StInit;
    endcase

    rd_data_d = rd_valid_d ? mem_q[rd_idx] : '0;
  end

  // Refresh: free-running interval counter after calibration; a pending refresh only stalls
  // the command port once the FSM is back in StIdle, so bursts are never cut.
  always_comb begin
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    stall_cnt_d = stall_cnt_q;
    if (RefreshEn && calib_q) begin
      if (ref_pend_q && (state_q == StIdle)) begin
        if (stall_cnt_q == StallLast) begin
          stall_cnt_d = '0;
          ref_pend_d  = 1'b0;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      if (ref_cnt_q == RefLast) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      calib_q     <= 1'b0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      stall_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_end_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      calib_q     <= calib_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      stall_cnt_q <= stall_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_end_q    <= rd_end_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < MaskW; b++) begin
        if (!app_wdf_mask_i[b]) begin
          mem_q[wr_idx][8*b +: 8] <= app_wdf_data_i[8*b +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wr_en) begin
      assert (app_wdf_end_i == (beat_q == LastBeat))
        else $error("app_wdf_end_i disagrees with write beat %0d", beat_q);
    end
  end
`endif

  assign app_rd_data_valid_o   = rd_valid_q;
  assign app_rd_data_o         = rd_data_q;
  assign app_rd_data_end_o     = rd_end_q;
  assign init_calib_complete_o = calib_q;

endmodule

// File: tb/tb_bp_dram_ui_responder.sv
// Scoreboard bench: drivers push expected read beats (data, end flag, arrival cycle) from a
// plain word-array model; a negedge monitor pops and compares every valid read beat.
module tb_bp_dram_ui_responder;

  localparam int unsigned Lat  = 4;
  localparam int unsigned Bl   = 8;
  localparam int unsigned Els  = 1024;
  localparam int unsigned Init = 16;
  localparam int unsigned RefI = 256;
  localparam int unsigned RefC = 8;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        app_en_i = 1'b0;
  logic        app_rdy_o;
  logic [2:0]  app_cmd_i = 3'b000;
  logic [27:0] app_addr_i = '0;
  logic        app_wdf_wren_i = 1'b0;
  logic [63:0] app_wdf_data_i = '0;
  logic [7:0]  app_wdf_mask_i = '0;
  logic        app_wdf_end_i = 1'b0;
  logic        app_wdf_rdy_o;
  logic        app_rd_data_valid_o;
  logic [63:0] app_rd_data_o;
  logic        app_rd_data_end_o;
  logic        init_calib_complete_o;

  bp_dram_ui_responder #(
    .ui_addr_width_p   (28),
    .ui_data_width_p   (64),
    .burst_len_p       (Bl),
    .els_p             (Els),
    .addr_shift_p      (1),
    .rd_latency_p      (Lat),
    .init_cycles_p     (Init),
    .refresh_interval_p(RefI),
    .refresh_cycles_p  (RefC)
  ) dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .app_en_i             (app_en_i),
    .app_rdy_o            (app_rdy_o),
    .app_cmd_i            (app_cmd_i),
    .app_addr_i           (app_addr_i),
    .app_wdf_wren_i       (app_wdf_wren_i),
    .app_wdf_data_i       (app_wdf_data_i),
    .app_wdf_mask_i       (app_wdf_mask_i),
    .app_wdf_end_i        (app_wdf_end_i),
    .app_wdf_rdy_o        (app_wdf_rdy_o),
    .app_rd_data_valid_o  (app_rd_data_valid_o),
    .app_rd_data_o        (app_rd_data_o),
    .app_rd_data_end_o    (app_rd_data_end_o),
    .init_calib_complete_o(init_calib_complete_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int unsigned cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] model_mem [Els];
  logic [63:0] wd [Bl];
  logic [7:0]  wm [Bl];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Word index of the burst a command address selects: shift, wrap, align down.
  function automatic int unsigned base_of(input logic [27:0] a);
    int unsigned w;
    w = (32'(a) >> 1) % Els;
    return w - (w % Bl);
  endfunction

  function automatic logic [27:0] make_addr(input int unsigned base);
    logic [16:0] hi;
    logic [9:0]  idx;
    hi  = 17'($urandom);
    idx = 10'(base + $urandom_range(0, Bl - 1));
    return {hi, idx, 1'($urandom)};
  endfunction

  // Monitor: every valid read beat must match the head of the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk_i);
      if (app_rd_data_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_beat", app_rd_data_valid_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", app_rd_data_o, e.data);
          check("rd_end", app_rd_data_end_o, e.last);
          check("rd_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_rdy();
    for (int i = 0; i < 64 && !app_rdy_o; i++) tick();
    if (!app_rdy_o) check("rdy_timeout", app_rdy_o, 1'b1);
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [27:0] addr, output int unsigned acc);
    wait_rdy();
    app_en_i   = 1'b1;
    app_cmd_i  = cmd;
    app_addr_i = addr;
    tick();
    acc      = cyc;
    app_en_i = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] addr);
    int unsigned acc;
    int unsigned b;
    b = base_of(addr);
    // Beat 0 is presented with the command and must be held until the port opens.
    app_wdf_wren_i = 1'b1;
    app_wdf_data_i = wd[0];
    app_wdf_mask_i = wm[0];
    app_wdf_end_i  = 1'b0;
    check("wdf_rdy_idle", app_wdf_rdy_o, 1'b0);
    issue(3'b000, addr, acc);
    for (int k = 0; k < Bl; k++) begin
      app_wdf_data_i = wd[k];
      app_wdf_mask_i = wm[k];
      app_wdf_end_i  = (k == Bl - 1);
      for (int t = 0; t < 16 && !app_wdf_rdy_o; t++) tick();
      if (!app_wdf_rdy_o) check("wdf_rdy_timeout", app_wdf_rdy_o, 1'b1);
      tick();
      for (int by = 0; by < 8; by++) begin
        if (!wm[k][by]) model_mem[b + k][8*by +: 8] = wd[k][8*by +: 8];
      end
    end
    app_wdf_wren_i = 1'b0;
    app_wdf_end_i  = 1'b0;
    check("wdf_rdy_done", app_wdf_rdy_o, 1'b0);
  endtask

  task automatic do_read(input logic [27:0] addr, output int unsigned acc);
    int unsigned b;
    beat_t e;
    b = base_of(addr);
    issue(3'b001, addr, acc);
    for (int k = 0; k < Bl; k++) begin
      e.data = model_mem[b + k];
      e.last = (k == Bl - 1);
      e.cyc  = acc + Lat + k;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdy"}, app_rdy_o, 1'b0);
    check({tag, "_wdf_rdy"}, app_wdf_rdy_o, 1'b0);
    check({tag, "_valid"}, app_rd_data_valid_o, 1'b0);
    check({tag, "_data"}, app_rd_data_o, 64'd0);
    check({tag, "_end"}, app_rd_data_end_o, 1'b0);
    check({tag, "_calib"}, init_calib_complete_o, 1'b0);
  endtask

  task automatic init_check(output int unsigned rise);
    int unsigned rel;
    rel  = cyc;
    rise = 0;
    for (int i = 0; i < 40 && rise == 0; i++) begin
      tick();
      if (init_calib_complete_o) rise = cyc;
    end
    check("calib_delay", rise - rel, Init);
    tick();
    check("rdy_after_calib", app_rdy_o, 1'b1);
  endtask

  initial begin
    int unsigned calib_edge;
    int unsigned acc;
    int unsigned first_low;
    int unsigned low_cnt;
    int unsigned pool [4];
    bit          written [4];
    int unsigned p;
    int unsigned op;

    // Reset and calibration
    tick(); tick(); tick();
    check_outputs_zero("reset");
    reset_n_i = 1'b1;
    check_outputs_zero("release");
    init_check(calib_edge);

    // Directed write / read at 0x10, masked rewrite, unaligned read
    for (int k = 0; k < Bl; k++) begin
      wd[k] = 64'h1000 + 64'(k);
      wm[k] = 8'h00;
    end
    do_write(28'h10);
    do_read(28'h10, acc);
    drain();
    for (int k = 0; k < Bl; k++) begin
      wd[k] = '1;
      wm[k] = (k == 0) ? 8'h0F : 8'hFF;
    end
    do_write(28'h10);
    do_read(28'h10, acc);
    drain();
    do_read(28'h16, acc);
    drain();

    // Refresh while idle: 8-cycle stall 256 cycles after calibration
    while (cyc < calib_edge + RefI - 16) tick();
    first_low = 0;
    low_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      if (!app_rdy_o) begin
        if (low_cnt == 0) first_low = cyc;
        low_cnt++;
      end
      tick();
    end
    check("refresh_start", first_low, calib_edge + RefI);
    check("refresh_len", low_cnt, RefC);

    // Refresh boundary inside a read burst: burst intact, stall follows the last beat
    while (cyc < calib_edge + 2 * RefI - 6) tick();
    do_read(28'h10, acc);
    drain();
    low_cnt = 0;
    while (!app_rdy_o && low_cnt < 20) begin
      low_cnt++;
      tick();
    end
    check("refresh_after_burst", low_cnt, RefC);

    // Reset during beat 3 of a read
    do_read(28'h10, acc);
    for (int i = 0; i < 64 && exp_q.size() > Bl - 4; i++) begin
      @(negedge clk_i);
      #2;
    end
    check("beats_before_reset", 64'(exp_q.size()), 64'(Bl - 4));
    reset_n_i = 1'b0;
    #1;
    check_outputs_zero("midburst_reset");
    exp_q.delete();
    tick(); tick();
    reset_n_i = 1'b1;
    init_check(calib_edge);

    // Randomized traffic with aliased addresses and invalid commands
    for (int i = 0; i < 4; i++) begin
      pool[i]    = $urandom_range(0, Els / Bl - 1) * Bl;
      written[i] = 1'b0;
    end
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      p  = $urandom_range(0, 3);
      if (op == 0) begin
        issue(3'($urandom_range(2, 7)), 28'($urandom), acc);
      end else if (op <= 4 || !written[p]) begin
        for (int k = 0; k < Bl; k++) begin
          wd[k] = {$urandom, $urandom};
          wm[k] = written[p] ? 8'($urandom) : 8'h00;
        end
        do_write(make_addr(pool[p]));
        written[p] = 1'b1;
      end else begin
        do_read(make_addr(pool[p]), acc);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
